// File: rtl/sub_32b_pipe.sv
// rtl/sub_32b_pipe.sv - pipelined 32-bit prefix-tree subtractor with valid/ready on both sides
// Optional stage-1 register: SUB_32B_PIPE_MID_REG_EN (undefined = single-stage, latency 1).
module sub_32b_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  if (WIDTH != 32) begin : g_width_check
    $error("sub_32b_pipe: only WIDTH=32 is supported");
  end

  // One Sklansky level: bits with bit 'lvl' set absorb the top of the lower half-block.
  function automatic logic [63:0] prefix_level(input logic [31:0] gi, input logic [31:0] pi,
                                               input int lvl);
    logic [31:0] go;
    logic [31:0] po;
    int          j;
    go = gi;
    po = pi;
    for (int i = 0; i < 32; i++) begin
      if (((i >> lvl) & 1) == 1) begin
        j = ((i >> lvl) << lvl) - 1;
        go[i[4:0]] = gi[i[4:0]] | (pi[i[4:0]] & gi[j[4:0]]);
        po[i[4:0]] = pi[i[4:0]] & pi[j[4:0]];
      end
    end
    return {go, po};
  endfunction

  logic [31:0] p0, g0;
  always_comb begin
    p0    = a ^ ~b;
    g0    = a & ~b;
    g0[0] = g0[0] | p0[0];  // carry-in of 1 folded into bit 0
  end

  logic        v2;
  logic        load2;
  logic [31:0] h_t;
  logic        a31_t, b31_t;
  logic [63:0] l1, l2, l3, l4, l5;

`ifdef SUB_32B_PIPE_MID_REG_EN
  logic        v1, load1;
  logic [31:0] g_s1, p_s1, h_s1;
  logic        a31_s1, b31_s1;

  assign in_ready = !v1 || !v2 || out_ready;
  assign load1    = in_valid && in_ready;
  assign load2    = v1 && (!v2 || out_ready);

  assign l1 = prefix_level(g0, p0, 0);
  assign l2 = prefix_level(l1[63:32], l1[31:0], 1);

  always_ff @(posedge clk) begin
    if (!rst_n)     v1 <= 1'b0;
    else if (load1) v1 <= 1'b1;
    else if (load2) v1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load1) begin
      g_s1   <= l2[63:32];
      p_s1   <= l2[31:0];
      h_s1   <= p0;
      a31_s1 <= a[31];
      b31_s1 <= b[31];
    end
  end

  assign l3    = prefix_level(g_s1, p_s1, 2);
  assign h_t   = h_s1;
  assign a31_t = a31_s1;
  assign b31_t = b31_s1;
`else
  assign in_ready = !v2 || out_ready;
  assign load2    = in_valid && in_ready;

  assign l1    = prefix_level(g0, p0, 0);
  assign l2    = prefix_level(l1[63:32], l1[31:0], 1);
  assign l3    = prefix_level(l2[63:32], l2[31:0], 2);
  assign h_t   = p0;
  assign a31_t = a[31];
  assign b31_t = b[31];
`endif

  assign l4 = prefix_level(l3[63:32], l3[31:0], 3);
  assign l5 = prefix_level(l4[63:32], l4[31:0], 4);

  // Group generate of bits i..0 is the carry into bit i+1.
  logic [31:0] carry, nd;
  logic        nbout, novf, nzero, unused_p;
  assign carry    = l5[63:32];
  assign unused_p = ^l5[31:0];
  assign nd       = h_t ^ {carry[30:0], 1'b1};
  assign nbout    = ~carry[31];
  assign novf     = (a31_t ^ b31_t) & (a31_t ^ nd[31]);
  assign nzero    = (nd == 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (load2) begin
      v2   <= 1'b1;
      d    <= nd;
      bout <= nbout;
      ovf  <= novf;
      zero <= nzero;
    end else if (out_ready) begin
      v2 <= 1'b0;
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_sub_32b_pipe.sv
// tb/tb_sub_32b_pipe.sv - self-checking bench for sub_32b_pipe
module tb_sub_32b_pipe;
`ifdef SUB_32B_PIPE_MID_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, d;
  logic        bout, ovf, zero;

  sub_32b_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    res_t        r;
  } vec_t;

  vec_t in_q[$];
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_emit = 0;
  bit   prev_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t r;
    r.d    = x - y;
    r.bout = (x < y);
    r.ovf  = (x[31] ^ y[31]) & (x[31] ^ r.d[31]);
    r.zero = (r.d == 32'd0);
    return r;
  endfunction

  task automatic add(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ed,
                     input logic eb, input logic eo, input logic ez);
    vec_t v;
    v.a = x; v.b = y; v.r.d = ed; v.r.bout = eb; v.r.ovf = eo; v.r.zero = ez;
    in_q.push_back(v);
  endtask

  task automatic add_m(input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v.a = x; v.b = y; v.r = model(x, y);
    in_q.push_back(v);
  endtask

  // One clock: drive just after the rising edge, observe on the falling edge.
  task automatic cycle(input bit want, input bit ordy);
    in_valid  = want && (in_q.size() != 0);
    a         = in_valid ? in_q[0].a : 32'h0;
    b         = in_valid ? in_q[0].b : 32'h0;
    out_ready = ordy;
    @(negedge clk);
    if (prev_stall) check("valid_held", {31'd0, out_valid}, 32'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        check("d", d, exp_q[0].d);
        check("bout", {31'd0, bout}, {31'd0, exp_q[0].bout});
        check("ovf", {31'd0, ovf}, {31'd0, exp_q[0].ovf});
        check("zero", {31'd0, zero}, {31'd0, exp_q[0].zero});
        if (out_ready) void'(exp_q.pop_front());
      end
      if (out_ready) n_emit++;
    end
    prev_stall = out_valid && !out_ready;
    if (in_valid && in_ready) begin
      exp_q.push_back(in_q[0].r);
      void'(in_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int k = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      if (rnd) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      else     cycle(1'b1, 1'b1);
      k++;
    end
    check("drain_done", in_q.size() + exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int n0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_d", d, 32'd0);
    check("rst_flags", {29'd0, bout, ovf, zero}, 32'd0);

    // Accept-to-result latency
    add(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("lat_after_accept", {31'd0, out_valid}, (LAT == 1) ? 32'd1 : 32'd0);
    cycle(1'b0, 1'b0);
    check("lat_result_valid", {31'd0, out_valid}, 32'd1);
    check("lat_result_d", d, 32'h0000_0002);
    drain(20, 1'b0);

    // Borrow, wrap, zero and signed-overflow corners
    add(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    add(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    add(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    add(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    add(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    add(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    add(32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    drain(40, 1'b0);

    // Backpressure: pipeline fills, then drains in order
    add(32'h0000_0064, 32'h0000_0001, 32'h0000_0063, 1'b0, 1'b0, 1'b0);
    add(32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    add(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    add(32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0);
    check("bp_accepts", 32'(4 - in_q.size()), 32'(LAT));
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_d_first", d, 32'h0000_0063);
    drain(40, 1'b0);

    // Sustained throughput: 6 pairs take exactly 6+LAT cycles
    n0 = n_emit;
    for (int i = 0; i < 6; i++) add_m(32'(i * 3 + 10), 32'(i));
    repeat (6 + LAT) cycle(1'b1, 1'b1);
    check("tput_emits", 32'(n_emit - n0), 32'd6);
    check("tput_empty", exp_q.size(), 32'd0);

    // Reset mid-stream drops everything in flight
    add_m(32'd10, 32'd20);
    add_m(32'd30, 32'd40);
    repeat (2) cycle(1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    in_q.delete();
    exp_q.delete();
    prev_stall = 1'b0;
    n0 = n_emit;
    repeat (5) cycle(1'b0, 1'b1);
    check("midrst_no_ghost", 32'(n_emit - n0), 32'd0);
    add(32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    drain(20, 1'b0);

    // Random operands with random handshakes against the arithmetic model
    for (int i = 0; i < 3000; i++) add_m(pick_operand(), pick_operand());
    drain(30000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
